// File: rtl/mm_cfg_master.sv
// Single-outstanding Avalon-MM configuration master: takes one read/write command,
// runs it on the bus with a bounded wait for read data, and presents one completion.
module mm_cfg_master #(
    parameter int ADDRESS_SIZE   = 8,
    parameter int REG_SIZE       = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_SIZE-1:0] cmd_address,
    input  logic [REG_SIZE-1:0]     cmd_writedata,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [REG_SIZE-1:0]     rsp_readdata,
    output logic                    rsp_timeout,

    output logic [ADDRESS_SIZE-1:0] mm_address,
    output logic                    mm_write,
    output logic [REG_SIZE-1:0]     mm_writedata,
    output logic                    mm_read,
    input  logic                    mm_waitrequest,
    input  logic                    mm_readdatavalid,
    input  logic [REG_SIZE-1:0]     mm_readdata
);

    // state   | meaning
    // IDLE    | ready for a command
    // REQ     | strobe on the bus, held while the slave stalls
    // WAIT_RD | read issued, waiting for read data or timeout
    // RESP    | completion presented until consumed
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q,    state_d;
    logic                    is_write_q, is_write_d;
    logic [ADDRESS_SIZE-1:0] addr_q,     addr_d;
    logic [REG_SIZE-1:0]     wdata_q,    wdata_d;
    logic [REG_SIZE-1:0]     rdata_q,    rdata_d;
    logic                    timeout_q,  timeout_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_write_d = cmd_write;
                    addr_d     = cmd_address;
                    wdata_d    = cmd_write ? cmd_writedata : '0;
                    rdata_d    = '0;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (!mm_waitrequest) begin
                    if (is_write_q) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Data arriving in the last counted cycle takes priority over the timeout.
                if (mm_readdatavalid) begin
                    rdata_d = mm_readdata;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is masked by rst so it stays low for the whole reset pulse.
    assign cmd_ready    = (state_q == IDLE) && !rst;

    assign mm_address   = addr_q;
    assign mm_writedata = wdata_q;
    assign mm_write     = (state_q == REQ) &&  is_write_q;
    assign mm_read      = (state_q == REQ) && !is_write_q;

    assign rsp_valid    = (state_q == RESP);
    assign rsp_write    = (state_q == RESP) && is_write_q;
    assign rsp_readdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_timeout  = (state_q == RESP) && timeout_q;

endmodule

// File: tb/tb_mm_cfg_master.sv
// Directed bench for mm_cfg_master (TIMEOUT_CYCLES=4): latency, stall, timeout,
// back-pressure and asynchronous reset behaviour with hand-computed expectations.
module tb_mm_cfg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_readdata;
    logic [7:0]  mm_address;
    logic        mm_write, mm_read, mm_waitrequest, mm_readdatavalid;
    logic [31:0] mm_writedata, mm_readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mm_cfg_master #(
        .ADDRESS_SIZE  (8),
        .REG_SIZE      (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_writedata   (cmd_writedata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_readdata    (rsp_readdata),
        .rsp_timeout     (rsp_timeout),
        .mm_address      (mm_address),
        .mm_write        (mm_write),
        .mm_writedata    (mm_writedata),
        .mm_read         (mm_read),
        .mm_waitrequest  (mm_waitrequest),
        .mm_readdatavalid(mm_readdatavalid),
        .mm_readdata     (mm_readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = addr;
        cmd_writedata = data;
        chk("accept_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_writedata = 0;
        rsp_ready = 0; mm_waitrequest = 0; mm_readdatavalid = 0; mm_readdata = 0;

        // reset state
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mm_rw", {mm_read, mm_write}, 0);
        tick(); tick();
        chk("rst_hold_cmd_ready", cmd_ready, 0);
        chk("rst_mm_address", mm_address, 0);
        rst = 1'b0;
        #1;
        chk("release_cmd_ready", cmd_ready, 1);

        // write 0x5A to 0x04, no stall
        send(1'b1, 8'h04, 32'h5A);
        chk("wr_c1_mm_write", mm_write, 1);
        chk("wr_c1_mm_read", mm_read, 0);
        chk("wr_c1_addr", mm_address, 32'h04);
        chk("wr_c1_data", mm_writedata, 32'h5A);
        chk("wr_c1_cmd_ready", cmd_ready, 0);
        chk("wr_c1_rsp_valid", rsp_valid, 0);
        tick();
        chk("wr_c2_mm_write", mm_write, 0);
        chk("wr_c2_rsp_valid", rsp_valid, 1);
        chk("wr_c2_rsp_write", rsp_write, 1);
        chk("wr_c2_rsp_rdata", rsp_readdata, 0);
        chk("wr_c2_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_done_rsp_valid", rsp_valid, 0);
        chk("wr_done_cmd_ready", cmd_ready, 1);

        // read 0x10 with 3 stall cycles, early stray readdatavalid ignored
        send(1'b0, 8'h10, 32'hFFFF_FFFF);
        mm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rd_stall_mm_read", mm_read, 1);
            chk("rd_stall_mm_write", mm_write, 0);
            chk("rd_stall_addr", mm_address, 32'h10);
            chk("rd_stall_wdata", mm_writedata, 0);
            if (i == 0) begin
                mm_readdatavalid = 1'b1;
                mm_readdata      = 32'h1111_1111;
            end
            tick();
            mm_readdatavalid = 1'b0;
            mm_readdata      = 32'h0;
        end
        mm_waitrequest = 1'b0;
        chk("rd_c4_mm_read", mm_read, 1);
        chk("rd_c4_addr", mm_address, 32'h10);
        tick();
        chk("rd_wait_mm_read", mm_read, 0);
        chk("rd_wait_rsp_valid", rsp_valid, 0);
        tick();
        mm_readdatavalid = 1'b1;
        mm_readdata      = 32'hDEAD_BEEF;
        chk("rd_rdv_rsp_valid", rsp_valid, 0);
        tick();
        mm_readdatavalid = 1'b0;
        mm_readdata      = 32'h0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_readdata, 32'hDEAD_BEEF);
        chk("rd_rsp_timeout", rsp_timeout, 0);
        chk("rd_rsp_write", rsp_write, 0);

        // completion back-pressure with a competing command
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 8'h22; cmd_writedata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_readdata, 32'hDEAD_BEEF);
            chk("bp_rsp_timeout", rsp_timeout, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_mm_write", mm_write, 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_done_rsp_valid", rsp_valid, 0);
        chk("bp_done_cmd_ready", cmd_ready, 1);
        tick();
        chk("bp_not_accepted", mm_write, 0);

        // read timeout after 4 WAIT_RD cycles, late data ignored
        send(1'b0, 8'h30, 32'h0);
        chk("to_mm_read", mm_read, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_rsp_valid", rsp_valid, 0);
            tick();
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_readdata, 0);
        mm_readdatavalid = 1'b1;
        mm_readdata      = 32'h0000_CAFE;
        tick();
        mm_readdatavalid = 1'b0;
        mm_readdata      = 32'h0;
        chk("to_late_rdata", rsp_readdata, 0);
        chk("to_late_timeout", rsp_timeout, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_done_rsp_valid", rsp_valid, 0);

        // data in the final timeout cycle wins
        send(1'b0, 8'h40, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("last_rsp_valid_pre", rsp_valid, 0);
        mm_readdatavalid = 1'b1;
        mm_readdata      = 32'h1234_5678;
        tick();
        mm_readdatavalid = 1'b0;
        mm_readdata      = 32'h0;
        chk("last_rsp_valid", rsp_valid, 1);
        chk("last_rsp_timeout", rsp_timeout, 0);
        chk("last_rsp_rdata", rsp_readdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset during a stalled REQ drops the strobe immediately
        send(1'b0, 8'h50, 32'h0);
        mm_waitrequest = 1'b1;
        #2;
        chk("rreq_mm_read_pre", mm_read, 1);
        rst = 1'b1;
        #1;
        chk("rreq_mm_read", mm_read, 0);
        chk("rreq_mm_address", mm_address, 0);
        chk("rreq_cmd_ready", cmd_ready, 0);
        mm_waitrequest = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rreq_release_ready", cmd_ready, 1);

        // reset during WAIT_RD discards the pending completion
        send(1'b0, 8'h60, 32'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rwait_rsp_valid", rsp_valid, 0);
        chk("rwait_cmd_ready", cmd_ready, 0);
        chk("rwait_mm_read", mm_read, 0);
        tick();
        rst = 1'b0;
        mm_readdatavalid = 1'b1;
        mm_readdata      = 32'hBAD0_BAD0;
        tick();
        mm_readdatavalid = 1'b0;
        mm_readdata      = 32'h0;
        chk("rwait_after_cmd_ready", cmd_ready, 1);
        chk("rwait_after_rsp_valid", rsp_valid, 0);
        chk("rwait_after_rdata", rsp_readdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_cfg_master.md
MM_CFG_MASTER -- requirements
Module: mm_cfg_master

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Parameter ADDRESS_SIZE, default 8, SHALL set the Avalon-MM address width.
REQ-003 Parameter REG_SIZE, default 32, SHALL set the Avalon-MM data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, SHALL set the read-response timeout (legal range >= 2).
REQ-005 Port clk, input, 1, SHALL be the single clock.
REQ-006 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-007 Port cmd_valid, input, 1, SHALL indicate that a command is offered.
REQ-008 Port cmd_ready, output, 1, SHALL indicate that the block accepts a command.
REQ-009 Port cmd_write, input, 1, SHALL select the command type: 1 = write, 0 = read.
REQ-010 Port cmd_address, input, ADDRESS_SIZE, SHALL carry the target register address.
REQ-011 Port cmd_writedata, input, REG_SIZE, SHALL carry the write data.
REQ-012 Port rsp_valid, output, 1, SHALL indicate that a completion is presented.
REQ-013 Port rsp_ready, input, 1, SHALL indicate that the consumer accepts the completion.
REQ-014 Port rsp_write, output, 1, SHALL indicate that the completion belongs to a write.
REQ-015 Port rsp_readdata, output, REG_SIZE, SHALL carry the read data (0 for writes and timeouts).
REQ-016 Port rsp_timeout, output, 1, SHALL indicate that the read response timed out.
REQ-017 Port mm_address, output, ADDRESS_SIZE, SHALL drive the Avalon-MM address.
REQ-018 Port mm_write, output, 1, SHALL drive the Avalon-MM write strobe.
REQ-019 Port mm_writedata, output, REG_SIZE, SHALL drive the Avalon-MM write data.
REQ-020 Port mm_read, output, 1, SHALL drive the Avalon-MM read strobe.
REQ-021 Port mm_waitrequest, input, 1, SHALL be the slave stall.
REQ-022 Port mm_readdatavalid, input, 1, SHALL be the slave read-data qualifier.
REQ-023 Port mm_readdata, input, REG_SIZE, SHALL be the slave read data.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, REQ, WAIT_RD, RESP.
REQ-025 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready, its fields are registered, and the FSM moves to REQ.
REQ-026 In REQ, exactly one of mm_write/mm_read SHALL be 1, with mm_address/mm_writedata driven from registers and held stable while mm_waitrequest=1; REQ SHALL hold indefinitely under waitrequest.
REQ-027 In REQ with mm_waitrequest=0: a write SHALL go to RESP (rsp_write=1, rsp_readdata=0, rsp_timeout=0); a read SHALL go to WAIT_RD with the timeout counter cleared.
REQ-028 mm_writedata SHALL be 0 during reads; mm_read and mm_write SHALL be 0 outside REQ.
REQ-029 WAIT_RD SHALL increment a counter each cycle (width $clog2(TIMEOUT_CYCLES)+1); mm_readdatavalid=1 SHALL capture mm_readdata into rsp_readdata and move to RESP with rsp_timeout=0.
REQ-030 After TIMEOUT_CYCLES WAIT_RD cycles without readdatavalid, the FSM SHALL move to RESP with rsp_timeout=1 and rsp_readdata=0.
REQ-031 If readdatavalid arrives in the final timeout cycle, the data SHALL win and no timeout SHALL be flagged.
REQ-032 mm_readdatavalid SHALL be ignored outside WAIT_RD, including late data after a timeout.
REQ-033 In RESP, rsp_valid=1 with all rsp_* fields stable until rsp_ready=1; the FSM SHALL then return to IDLE.
REQ-034 Minimum latency SHALL be: write accepted at cycle 0 -> mm_write at cycle 1 -> rsp_valid at cycle 2; read -> mm_read at cycle 1, readdatavalid earliest cycle 2, rsp_valid at cycle 3.
REQ-035 At most one Avalon transaction SHALL be outstanding at any time.

Reset
REQ-036 While rst=1, the FSM SHALL be in IDLE and all outputs SHALL be 0, including cmd_ready; cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-037 Reset asserted mid-transaction SHALL drop mm_read/mm_write immediately and SHALL discard the pending completion.

Verification
REQ-038 Write 0x5A to address 0x04 with waitrequest=0 -> mm_write=1 for one cycle with addr 0x04, data 0x5A; rsp_valid at cycle 2 with rsp_write=1.
REQ-039 Read address 0x10 with waitrequest held for 3 cycles, then readdatavalid 2 cycles after accept with data 0xDEADBEEF -> mm_read held for 4 cycles with stable address; rsp_readdata=0xDEADBEEF, rsp_timeout=0.
REQ-040 Read with no readdatavalid and TIMEOUT_CYCLES=4 -> rsp_valid after 4 WAIT_RD cycles with rsp_timeout=1 and rsp_readdata=0; a later readdatavalid is ignored.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, and a new cmd_valid is not accepted.
REQ-042 rst pulse while in WAIT_RD -> all outputs 0 asynchronously; cmd_ready=1 the cycle after release; no stale rsp_valid.
